// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Optional build macro: PIPE_PERF_CNT_EN (stall/flush cycle counters).
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int REG_W       = 5;
  localparam int TIMEOUT_DEF = 64;
  localparam int PERF_W      = 32;

  typedef struct packed {
    logic mem_req;
    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c          = '0;
    c.pc_write = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_gstall();
    ctrl_t c;
    c              = '0;
    c.if_id_stall  = 1'b1;
    c.id_ex_stall  = 1'b1;
    c.ex_mem_stall = 1'b1;
    c.mem_wb_stall = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c             = '0;
    c.if_id_stall = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_branch();
    ctrl_t c;
    c             = ctrl_idle();
    c.if_id_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Load-use detector: ID/EX load whose rd feeds the IF/ID instruction.
// Purely combinational; x0 never creates a hazard.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic             id_ex_memread_i,
  input  logic [REG_W-1:0] id_ex_rd_i,
  input  logic [REG_W-1:0] if_id_rs1_i,
  input  logic [REG_W-1:0] if_id_rs2_i,
  output logic             lu_o
);

  logic rd_nz;
  logic rs_hit;

  always_comb begin
    rd_nz  = (id_ex_rd_i != '0);
    rs_hit = (id_ex_rd_i == if_id_rs1_i)
          || (id_ex_rd_i == if_id_rs2_i);
    lu_o   = id_ex_memread_i && rd_nz && rs_hit;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer and data-memory handshake FSM.
// Optional build macro: PIPE_PERF_CNT_EN (stall/flush cycle counters).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             id_ex_memread_i,
  input  logic [REG_W-1:0] id_ex_rd_i,
  input  logic [REG_W-1:0] if_id_rs1_i,
  input  logic [REG_W-1:0] if_id_rs2_i,
  input  logic             branch_taken_i,
  input  logic             ex_mem_memread_i,
  input  logic             ex_mem_memwrite_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_stall_o,
  output logic             err_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
`endif
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic  run;
  logic  access;
  logic  lu;
  logic  gstall;
  logic  req;
  ctrl_t ctrl;

  hazard_unit u_hazard (
    .id_ex_memread_i (id_ex_memread_i),
    .id_ex_rd_i      (id_ex_rd_i),
    .if_id_rs1_i     (if_id_rs1_i),
    .if_id_rs2_i     (if_id_rs2_i),
    .lu_o            (lu)
  );

  // Reset also gates the outputs so a request drops the instant reset hits.
  assign run    = start_i & rst_n_i;
  assign access = ex_mem_memread_i | ex_mem_memwrite_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    gstall  = 1'b0;
    req     = 1'b0;
    if (!run) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access) begin
            req     = 1'b1;
            gstall  = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
        WAIT: begin
          req = 1'b1;
          if (mem_ack_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            gstall = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Fixed priority: memory stall, then load-use bubble, then branch flush.
  always_comb begin
    ctrl = ctrl_idle();
    if (run) begin
      if (gstall) begin
        ctrl = ctrl_gstall();
      end else if (lu) begin
        ctrl = ctrl_load_use();
      end else if (branch_taken_i) begin
        ctrl = ctrl_branch();
      end
      ctrl.mem_req = req;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o      = ctrl.mem_req;
  assign pc_write_o     = ctrl.pc_write;
  assign if_id_stall_o  = ctrl.if_id_stall;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_stall_o  = ctrl.id_ex_stall;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_stall_o = ctrl.ex_mem_stall;
  assign mem_wb_stall_o = ctrl.mem_wb_stall;
  assign err_o          = err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic              stall_ev;
  logic              flush_ev;

  assign stall_ev = run & (gstall | lu);
  assign flush_ev = ctrl.if_id_flush | ctrl.id_ex_flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!run) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_ev && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives stall_i of every pipeline register, including EX_MEM, plus the PC write enable and the IF/ID and ID/EX flushes.
- Runs the data-memory request/acknowledge handshake for the instruction held in EX/MEM.
- Resolves load-use hazards and taken-branch flushes with a fixed priority, so pipeline registers never receive conflicting controls.

Parameters:
- TIMEOUT, 64: maximum WAIT cycles before the memory access is abandoned; range 2..255.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  synchronous run enable; low forces the idle state.
- id_ex_memread_i  in  1  MemRead of the instruction in ID/EX.
- id_ex_rd_i  in  5  destination register in ID/EX.
- if_id_rs1_i  in  5  rs1 field of the instruction in IF/ID.
- if_id_rs2_i  in  5  rs2 field of the instruction in IF/ID.
- branch_taken_i  in  1  branch resolved taken in ID.
- ex_mem_memread_i  in  1  MemRead held in EX/MEM.
- ex_mem_memwrite_i  in  1  MemWrite held in EX/MEM.
- mem_ack_i  in  1  data memory completes the request.
- mem_req_o  out  1  data memory request.
- pc_write_o  out  1  PC update enable.
- if_id_stall_o  out  1  hold IF/ID.
- if_id_flush_o  out  1  zero IF/ID.
- id_ex_stall_o  out  1  hold ID/EX.
- id_ex_flush_o  out  1  insert bubble into ID/EX.
- ex_mem_stall_o  out  1  hold EX/MEM; connects to that register's stall_i.
- mem_wb_stall_o  out  1  hold MEM/WB.
- err_o  out  1  sticky memory timeout flag.

Behaviour:
- Reset:
  - Registered state: IDLE, timeout counter 0, err_o 0.
  - Outputs: mem_req_o 0, pc_write_o 1, every stall and flush output 0.
- start_i low:
  - Next state IDLE, counter cleared.
  - Outputs forced to their reset values; err_o holds its value.
- Definitions:
  - access = ex_mem_memread_i | ex_mem_memwrite_i.
  - lu = id_ex_memread_i & (id_ex_rd_i != 0) & (id_ex_rd_i == if_id_rs1_i | id_ex_rd_i == if_id_rs2_i).
- FSM states: IDLE, WAIT.
  - IDLE, access=1: mem_req_o=1, gstall=1, next WAIT, counter cleared to 0.
  - IDLE, access=0: gstall=0, stay IDLE.
  - WAIT, mem_ack_i=0: mem_req_o=1, gstall=1, counter increments.
  - WAIT, counter reaches TIMEOUT-1 with no ack: next IDLE, err_o set, gstall dropped this cycle; the access is abandoned and the pipeline advances.
  - WAIT, mem_ack_i=1: mem_req_o=1, gstall=0 in the same cycle so the pipeline advances, next IDLE.
  - A back-to-back access re-enters WAIT on the following cycle.
- mem_ack_i seen in IDLE is ignored.
- Minimum memory-op cost: 1 stall cycle; ack on the first WAIT cycle.
- gstall=1 outputs:
  - pc_write_o=0.
  - if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_stall_o all 1.
  - if_id_flush_o=0, id_ex_flush_o=0; flushes are suppressed, and a pending branch or load-use is re-evaluated after release.
- gstall=0 and lu=1: pc_write_o=0, if_id_stall_o=1, id_ex_flush_o=1, other stalls 0, if_id_flush_o=0 (branch ignored this cycle).
- gstall=0, lu=0, branch_taken_i=1: if_id_flush_o=1, pc_write_o=1.
- Priority: gstall > lu > branch.
- Outputs are combinational from registered state and inputs; no registered latency beyond the FSM.
- Reset asserted mid-WAIT: the request drops immediately (asynchronous reset).

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs stall_cnt_o[31:0], counting cycles with gstall | lu.
  - Adds outputs flush_cnt_o[31:0], counting cycles with if_id_flush_o | id_ex_flush_o.
  - Both counters saturate at 0xFFFFFFFF, clear on reset and on start_i low.
- Without the macro: no such ports or logic.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (IDLE=1'b0, WAIT=1'b1);
  - the register-index width constant REG_W=5;
  - the default TIMEOUT.
- One combinational sub-module, hazard_unit, computes lu from the ID/EX and IF/ID fields; pipe_ctrl instantiates it.

Test Plan:
- Load with ack on the 3rd WAIT cycle:
  - mem_req_o high 4 cycles;
  - ex_mem_stall_o high 3 cycles, low in the ack cycle;
  - state IDLE afterward.
- lu hazard (id_ex_rd_i=5, memread=1, if_id_rs2_i=5), no access: pc_write_o=0, if_id_stall_o=1, id_ex_flush_o=1 for exactly 1 cycle.
- lu with id_ex_rd_i=0 matching rs1=0: no stall, no flush.
- branch_taken_i=1 during gstall: no if_id_flush_o until ack; then flush asserted if branch_taken_i is still held.
- TIMEOUT=4, ack never arrives: gstall for 4 cycles, err_o rises and stays high; next access still issues mem_req_o.
- rst_n_i low mid-WAIT: mem_req_o and all stalls go low immediately; after release, FSM is IDLE and err_o is 0.
